reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Shares the register file's single write port between the in-order pipeline writeback stage (WB) and the multi-cycle M-extension mul/div unit (MD). Tracks registers with an outstanding MD result so the decode-stage hazard logic can stall dependent instructions. Escalates to a pipeline stall if MD is starved. Sits between the WB/MD units and `reg_file`, driving its WRITE_ENABLE/WRITE_ADDRESS/WRITE_DATA inputs.

## Interface
- MAX_WAIT, 4: consecutive refused MD cycles before STALL_PIPE asserts (range 1-15).
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- WB_VALID  in  1  WB has a result this cycle; never back-pressured.
- WB_ADDR  in  5  WB destination register.
- WB_DATA  in  32  WB result.
- MD_VALID  in  1  MD result pending; held with MD_ADDR/MD_DATA until MD_READY.
- MD_ADDR  in  5  MD destination register.
- MD_DATA  in  32  MD result.
- MD_READY  out  1  MD result accepted this cycle (combinational).
- ISSUE_VALID  in  1  a mul/div instruction is dispatched to MD this cycle.
- ISSUE_ADDR  in  5  its destination register.
- RS1_ADDR, RS2_ADDR  in  5 each  decode-stage source registers.
- RS1_BUSY, RS2_BUSY  out  1 each  source has an outstanding MD write (combinational from busy vector).
- STALL_PIPE  out  1  registered; requests pipeline freeze so MD can write.
- WRITE_ENABLE  out  1  registered; to reg_file.
- WRITE_ADDRESS  out  5  registered; to reg_file.
- WRITE_DATA  out  32  registered; to reg_file.

## Operation
- Grant: WB_VALID wins unconditionally. MD_READY = MD_VALID & !WB_VALID.
- Winner's addr/data registered onto WRITE_*; WRITE_ENABLE = grant & (addr != 0). No grant: WRITE_ENABLE=0, WRITE_ADDRESS/WRITE_DATA hold.
- Busy vector (32 bits): ISSUE_VALID & ISSUE_ADDR!=0 sets bit; MD handshake clears bit MD_ADDR. Same-address set and clear in one cycle: set wins. Bit 0 always 0.
- RSx_BUSY = busy[RSx_ADDR]; additionally 1 if the MD handshake for that register has occurred but WRITE_ENABLE has not yet committed it is NOT required: clearing is timed so the read sees reg_file updated (see Timing).
- FSM: IDLE (MD_VALID=0); WAIT (MD_VALID=1, refused, counter counting); STALL (STALL_PIPE=1).
  - IDLE->WAIT: MD_VALID & WB_VALID. IDLE stays on MD handshake.
  - WAIT: counter +1 per refused cycle; counter==MAX_WAIT-1 with another refusal -> STALL. Handshake -> IDLE, counter=0.
  - STALL: pipeline guarantees WB_VALID=0 from the next cycle; MD handshake -> IDLE, STALL_PIPE=0 next cycle. WB_VALID still high in STALL still wins (no write lost).
- Counter 4 bits, saturates, never wraps.

## Timing
- Reset values: WRITE_ENABLE=0, WRITE_ADDRESS=0, WRITE_DATA=0, STALL_PIPE=0, busy=0, counter=0, FSM=IDLE. RESET mid-handshake drops pending write and all busy bits.
- Grant in cycle N -> WRITE_* valid during N+1 -> reg_file written at end of N+1.
- Busy bit for MD clears at the edge ending N+1 (one cycle after handshake), so RSx_BUSY drops exactly when the data is in reg_file.
- ISSUE in cycle N -> RSx_BUSY high from N+1.
- STALL_PIPE rises the cycle after the MAX_WAIT-th refusal; falls the cycle after MD handshake.

## Structure
- Shared package: XLEN=32, REG_ADDR_W=5, ZERO_REG=0, FSM state encodings (IDLE/WAIT/STALL).
- One sub-module: `reg_scoreboard` (busy vector, set/clear with delayed clear, two read ports).

## Test plan
- WB_VALID, WB_ADDR=3, WB_DATA=0x55 alone -> next cycle WRITE_ENABLE=1, WRITE_ADDRESS=3, WRITE_DATA=0x55; reg 3 reads 0x55.
- MD_VALID addr 5 data 0xAA with WB_VALID addr 6 same cycle -> MD_READY=0, reg 6 written first; next cycle WB idle -> MD_READY=1, reg 5=0xAA.
- ISSUE_ADDR=7, RS1_ADDR=7 -> RS1_BUSY=1 next cycle; stays 1 until cycle after MD write to 7, then 0 with reg 7 holding MD_DATA.
- WB_VALID held 4 cycles with MD_VALID (MAX_WAIT=4) -> STALL_PIPE=1 in cycle 5; drop WB_VALID -> MD accepted, STALL_PIPE=0 following cycle.
- WB write to x0 value 10 and ISSUE_ADDR=0 -> WRITE_ENABLE=0, reg 0 reads 0, RS1_BUSY for x0 stays 0.
- RESET asserted while busy[9]=1 and STALL_PIPE=1 -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared widths, register constants and arbiter FSM encoding for the
// register-file write-port arbiter.
package reg_write_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_STALL = 2'd2
  } arb_state_t;

  // Refusal counter stops at all-ones instead of wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] val);
    return (val == 4'hF) ? 4'hF : val + 4'd1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// WB / MD / decode / reg_file signal bundle around the write-port arbiter.
interface reg_write_arbiter_if;
  import reg_write_arbiter_pkg::*;

  logic                  WB_VALID;
  logic [REG_ADDR_W-1:0] WB_ADDR;
  logic [XLEN-1:0]       WB_DATA;
  logic                  MD_VALID;
  logic [REG_ADDR_W-1:0] MD_ADDR;
  logic [XLEN-1:0]       MD_DATA;
  logic                  MD_READY;
  logic                  ISSUE_VALID;
  logic [REG_ADDR_W-1:0] ISSUE_ADDR;
  logic [REG_ADDR_W-1:0] RS1_ADDR;
  logic [REG_ADDR_W-1:0] RS2_ADDR;
  logic                  RS1_BUSY;
  logic                  RS2_BUSY;
  logic                  STALL_PIPE;
  logic                  WRITE_ENABLE;
  logic [REG_ADDR_W-1:0] WRITE_ADDRESS;
  logic [XLEN-1:0]       WRITE_DATA;

  modport master (
    output WB_VALID, WB_ADDR, WB_DATA, MD_VALID, MD_ADDR, MD_DATA,
           ISSUE_VALID, ISSUE_ADDR, RS1_ADDR, RS2_ADDR,
    input  MD_READY, RS1_BUSY, RS2_BUSY, STALL_PIPE,
           WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA
  );

  modport slave (
    input  WB_VALID, WB_ADDR, WB_DATA, MD_VALID, MD_ADDR, MD_DATA,
           ISSUE_VALID, ISSUE_ADDR, RS1_ADDR, RS2_ADDR,
    output MD_READY, RS1_BUSY, RS2_BUSY, STALL_PIPE,
           WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA
  );

endinterface

// File: rtl/reg_write_arbiter_scoreboard.sv
// Busy vector of registers awaiting an MD result. The clear is delayed one
// cycle so a source drops busy exactly when reg_file holds the new value.
module reg_scoreboard
  import reg_write_arbiter_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic                  rd_busy_a,
  output logic                  rd_busy_b
);

  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;
  logic                  clr_pend_q;
  logic [REG_ADDR_W-1:0] clr_addr_q;
  logic                  set_hit;

  assign set_hit = set_en && (set_addr != ZERO_REG);

  // A re-issue to the register being retired cancels the retirement.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      busy_q     <= '0;
      clr_pend_q <= 1'b0;
      clr_addr_q <= ZERO_REG;
    end else begin
      busy_q     <= busy_d;
      clr_pend_q <= clr_en && !(set_hit && (set_addr == clr_addr));
      clr_addr_q <= clr_addr;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (clr_pend_q) busy_d[clr_addr_q] = 1'b0;
    if (set_hit)    busy_d[set_addr]   = 1'b1;
    busy_d[0] = 1'b0;
  end

  assign rd_busy_a = busy_q[rd_addr_a];
  assign rd_busy_b = busy_q[rd_addr_b];

endmodule

// File: rtl/reg_write_arbiter.sv
// Single reg_file write port shared by WB (always wins) and the mul/div unit,
// with a starvation FSM that freezes the pipeline so MD can drain.
//
// state    | meaning
// ST_IDLE  | no refused MD result outstanding
// ST_WAIT  | MD result refused, counting consecutive refusals
// ST_STALL | STALL_PIPE asserted until MD is accepted
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic           CLK,
  input  logic           RESET,
  reg_write_arbiter_if.slave bus
);

  localparam logic [3:0] LAST_CNT = 4'(MAX_WAIT - 1);

  arb_state_t            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  stall_q;
  logic                  we_q;
  logic [REG_ADDR_W-1:0] waddr_q;
  logic [XLEN-1:0]       wdata_q;
  logic                  md_hs;
  logic                  md_refused;

  assign md_hs      = bus.MD_VALID && !bus.WB_VALID;
  assign md_refused = bus.MD_VALID && bus.WB_VALID;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      stall_q <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= ZERO_REG;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= (state_d == ST_STALL);
      if (bus.WB_VALID) begin
        we_q    <= (bus.WB_ADDR != ZERO_REG);
        waddr_q <= bus.WB_ADDR;
        wdata_q <= bus.WB_DATA;
      end else if (bus.MD_VALID) begin
        we_q    <= (bus.MD_ADDR != ZERO_REG);
        waddr_q <= bus.MD_ADDR;
        wdata_q <= bus.MD_DATA;
      end else begin
        we_q    <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (md_refused) begin
          cnt_d   = 4'd1;
          state_d = (MAX_WAIT <= 1) ? ST_STALL : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!bus.MD_VALID || md_hs) begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = sat_inc4(cnt_q);
          if (cnt_q >= LAST_CNT) state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        if (!bus.MD_VALID || md_hs) begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = sat_inc4(cnt_q);
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  reg_scoreboard u_scoreboard (
    .CLK       (CLK),
    .RESET     (RESET),
    .set_en    (bus.ISSUE_VALID),
    .set_addr  (bus.ISSUE_ADDR),
    .clr_en    (md_hs),
    .clr_addr  (bus.MD_ADDR),
    .rd_addr_a (bus.RS1_ADDR),
    .rd_addr_b (bus.RS2_ADDR),
    .rd_busy_a (bus.RS1_BUSY),
    .rd_busy_b (bus.RS2_BUSY)
  );

  assign bus.MD_READY      = md_hs;
  assign bus.STALL_PIPE    = stall_q;
  assign bus.WRITE_ENABLE  = we_q;
  assign bus.WRITE_ADDRESS = waddr_q;
  assign bus.WRITE_DATA    = wdata_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a small reg_file model on WRITE_*.
module tb_reg_write_arbiter;
  import reg_write_arbiter_pkg::*;

  logic CLK = 1'b0;
  logic RESET;
  int   total = 0;
  int   bad   = 0;

  reg_write_arbiter_if bus ();

  reg_write_arbiter #(.MAX_WAIT(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  logic [XLEN-1:0] rf [NUM_REGS];
  always @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (bus.WRITE_ENABLE) begin
      rf[bus.WRITE_ADDRESS] <= bus.WRITE_DATA;
    end
  end

  typedef struct packed {
    logic        wbv;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        mdv;
    logic [4:0]  mda;
    logic [31:0] mdd;
    logic        isv;
    logic [4:0]  isa;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        x_rdy;
    logic        x_we;
    logic [4:0]  x_wa;
    logic [31:0] x_wd;
    logic        x_b1;
    logic        x_b2;
    logic        x_st;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wbv, input logic [4:0] wba, input logic [31:0] wbd,
                       input logic mdv, input logic [4:0] mda, input logic [31:0] mdd,
                       input logic isv, input logic [4:0] isa,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    bus.WB_VALID    = wbv;
    bus.WB_ADDR     = wba;
    bus.WB_DATA     = wbd;
    bus.MD_VALID    = mdv;
    bus.MD_ADDR     = mda;
    bus.MD_DATA     = mdd;
    bus.ISSUE_VALID = isv;
    bus.ISSUE_ADDR  = isa;
    bus.RS1_ADDR    = rs1;
    bus.RS2_ADDR    = rs2;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd3, 32'h55, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 5'd6, 32'h66, 1'b1, 5'd5, 32'hAA, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd6, 32'h66, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'hAA, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 32'hAA, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 5'd5, 32'hAA, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd7, 1'b0, 1'b0, 5'd5, 32'hAA, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd0, 1'b1, 1'b1, 5'd7, 32'h77, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 32'h77, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 5'd0, 32'd10, 1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd10, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 5'd9, 5'd9, 1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 32'h99, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 32'h9A, 1'b0, 5'd0, 5'd9, 5'd0, 1'b1, 1'b1, 5'd9, 32'h9A, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 32'h9A, 1'b0, 1'b0, 1'b0};

    RESET = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    tick();
    check("rst_we",    32'(bus.WRITE_ENABLE),  32'd0);
    check("rst_waddr", 32'(bus.WRITE_ADDRESS), 32'd0);
    check("rst_wdata", bus.WRITE_DATA,         32'd0);
    check("rst_stall", 32'(bus.STALL_PIPE),    32'd0);
    check("rst_busy",  32'({bus.RS1_BUSY, bus.RS2_BUSY}), 32'd0);
    RESET = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].wbv, vecs[i].wba, vecs[i].wbd, vecs[i].mdv, vecs[i].mda, vecs[i].mdd,
            vecs[i].isv, vecs[i].isa, vecs[i].rs1, vecs[i].rs2);
      #1;
      check($sformatf("v%0d_md_ready", i), 32'(bus.MD_READY), 32'(vecs[i].x_rdy));
      tick();
      check($sformatf("v%0d_we", i),    32'(bus.WRITE_ENABLE),  32'(vecs[i].x_we));
      check($sformatf("v%0d_waddr", i), 32'(bus.WRITE_ADDRESS), 32'(vecs[i].x_wa));
      check($sformatf("v%0d_wdata", i), bus.WRITE_DATA,         vecs[i].x_wd);
      check($sformatf("v%0d_rs1_busy", i), 32'(bus.RS1_BUSY),   32'(vecs[i].x_b1));
      check($sformatf("v%0d_rs2_busy", i), 32'(bus.RS2_BUSY),   32'(vecs[i].x_b2));
      check($sformatf("v%0d_stall", i), 32'(bus.STALL_PIPE),    32'(vecs[i].x_st));
    end

    check("rf3", rf[3], 32'h55);
    check("rf6", rf[6], 32'h66);
    check("rf5", rf[5], 32'hAA);
    check("rf7", rf[7], 32'h77);
    check("rf0", rf[0], 32'h0);
    check("rf1", rf[1], 32'h11);
    check("rf9", rf[9], 32'h9A);

    // MD starved by four consecutive WB writes
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 5'd2, 32'(k), 1'b1, 5'd12, 32'hC0C0, 1'b0, 5'd0, 5'd0, 5'd0);
      #1;
      check($sformatf("starve%0d_md_ready", k), 32'(bus.MD_READY), 32'd0);
      tick();
      check($sformatf("starve%0d_stall", k), 32'(bus.STALL_PIPE), (k == 4) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC0C0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    check("drain_md_ready", 32'(bus.MD_READY), 32'd1);
    tick();
    check("drain_stall", 32'(bus.STALL_PIPE),    32'd0);
    check("drain_we",    32'(bus.WRITE_ENABLE),  32'd1);
    check("drain_waddr", 32'(bus.WRITE_ADDRESS), 32'd12);
    check("drain_wdata", bus.WRITE_DATA,         32'hC0C0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    check("rf2",  rf[2],  32'd4);
    check("rf12", rf[12], 32'hC0C0);

    // Reset while x9 busy and the pipeline is stalled, mid-handshake
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
    tick();
    check("pre_rst_busy9", 32'(bus.RS1_BUSY), 32'd1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'd2, 32'h20, 1'b1, 5'd13, 32'hD0D0, 1'b0, 5'd0, 5'd9, 5'd0);
      tick();
    end
    check("pre_rst_stall", 32'(bus.STALL_PIPE), 32'd1);
    RESET = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hD0D0, 1'b0, 5'd0, 5'd9, 5'd0);
    tick();
    check("mid_rst_we",    32'(bus.WRITE_ENABLE),  32'd0);
    check("mid_rst_waddr", 32'(bus.WRITE_ADDRESS), 32'd0);
    check("mid_rst_wdata", bus.WRITE_DATA,         32'd0);
    check("mid_rst_stall", 32'(bus.STALL_PIPE),    32'd0);
    check("mid_rst_busy9", 32'(bus.RS1_BUSY),      32'd0);
    RESET = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
    tick();
    check("post_rst_we",    32'(bus.WRITE_ENABLE), 32'd0);
    check("post_rst_stall", 32'(bus.STALL_PIPE),   32'd0);
    check("post_rst_rf9",   rf[9],                 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
